regfile_rdctl: RTL
==================

Name: regfile_rdctl

Overview:
- Read-side controller for the PQR5 register file; sits between decode and execute.
- Accepts source-register addresses and a payload over a valid/ready handshake, and drives the register file's shared read enable and its two synchronous read ports.
- Returns both operands with the payload one cycle later.
- Snoops the write port, so returned operands are never stale across a same-cycle write or a downstream stall. This is needed because the register file has no write-to-read bypass and holds its read data while the read enable is low.

Parameters:
- XLEN, 32, data width of registers and operands.
- PLD_W, 32, width of the pass-through payload (decoded instruction info).
- FWD_EN, 1, 1 enables write-snoop override; 0 passes register-file data straight through.

Ports:
- clk  in  1  clock.
- sreset  in  1  reset; synchronous, active-high.
- i_flush  in  1  synchronous pipeline flush; kills the held operation.
- i_vld  in  1  upstream request valid.
- o_rdy  out  1  upstream ready.
- i_rs0_addr  in  5  source register 0 address.
- i_rs1_addr  in  5  source register 1 address.
- i_payload  in  PLD_W  payload carried alongside the operands.
- o_rf_rden  out  1  register-file read enable.
- o_rf_rs0_addr  out  5  register-file port-0 address.
- o_rf_rs1_addr  out  5  register-file port-1 address.
- i_rf_rs0_data  in  XLEN  register-file port-0 read data (registered inside the register file).
- i_rf_rs1_data  in  XLEN  register-file port-1 read data.
- i_wb_wren  in  1  snooped register-file write enable.
- i_wb_rdt_addr  in  5  snooped write address.
- i_wb_rdt_data  in  XLEN  snooped write data.
- o_vld  out  1  operands valid.
- i_rdy  in  1  downstream ready.
- o_rs0_data  out  XLEN  operand 0.
- o_rs1_data  out  XLEN  operand 1.
- o_rs0_addr  out  5  address of operand 0 (held copy).
- o_rs1_addr  out  5  address of operand 1 (held copy).
- o_payload  out  PLD_W  payload.

Behaviour:
- State: two states, EMPTY (o_vld=0) and FULL (o_vld=1). o_vld is a register.
- o_rdy = ~i_flush & (~o_vld | i_rdy). Combinational, so a new request can be accepted in the same cycle the held one transfers, giving full throughput.
- acc = i_vld & o_rdy.
- Register-file drive (combinational): o_rf_rden = acc, o_rf_rs0_addr = i_rs0_addr, o_rf_rs1_addr = i_rs1_addr.
  - Read enable is low whenever nothing is accepted, so the register-file read registers hold the operands through a stall.
- On acc: next o_vld=1; capture the addresses into o_rsX_addr and the payload into o_payload.
- If FULL & i_rdy & ~acc: next o_vld=0.
- Latency: data for a request accepted in cycle N is valid on o_rsX_data in cycle N+1.
- Override per operand X (FWD_EN=1): one flag ovrX plus one data register ovrX_data. o_rsX_data = ovrX ? ovrX_data : i_rf_rsX_data.
- Accept-cycle collision: the register file reads the old value at the same edge as the write. If acc & i_wb_wren & i_wb_rdt_addr==i_rsX_addr & i_rsX_addr!=0, set ovrX and load ovrX_data with i_wb_rdt_data. On acc without a collision, clear ovrX.
- Hold-cycle update: if FULL & ~i_rdy & i_wb_wren & i_wb_rdt_addr==o_rsX_addr & o_rsX_addr!=0, set ovrX and load the new data. The latest write wins.
- Address 0 is never overridden; operand 0 reads as 0 through the register file.
- Both operands with the same address: both are overridden independently, with identical results.
- Transfer with no new accept: clear ovrX.
- Transfer and accept in the same cycle: the flags are evaluated for the new request only.
- FWD_EN=0: ovrX is held at 0.
- Flush: i_flush forces o_rdy=0 (no accept). Next cycle o_vld=0 and ovr0=ovr1=0; o_payload and addresses are don't-care. Flush has priority over i_rdy.
- Reset (sreset=1 at a clk edge): o_vld=0, ovr0=ovr1=0, o_payload=0, o_rs0_addr=o_rs1_addr=0. o_rdy reads 1 once reset is released.
  - Reset mid-operation drops the held operation.
  - o_rsX_data after reset reflects register-file output, which is undefined (no reset in the register file) and must not be sampled while o_vld=0.
- While FULL and stalled, o_rsX_data, o_rsX_addr and o_payload are stable unless a snooped write hits a held address.

Test Plan:
- Basic read: x5=0x11, x6=0x22; request rs0=5, rs1=6, payload 0xA5 -> next cycle o_vld=1, o_rs0_data=0x11, o_rs1_data=0x22, o_payload=0xA5; o_rf_rden pulses exactly once.
- Accept-cycle collision: x7=0x1; request rs0=7 while a write to x7 of 0x99 occurs in the same cycle -> o_rs0_data=0x99, not 0x1.
- Stall update: FULL holding rs1=9 (0x5), i_rdy=0 for 3 cycles, writes to x9 of 0x6 then 0x7 -> o_rs1_data goes 0x5, then 0x6, then 0x7; after i_rdy=1 transfers 0x7; o_rf_rden stays 0 throughout the stall.
- x0 guard: request rs0=0 with a simultaneous write to x0 of 0xFFFF -> o_rs0_data=0.
- Back-to-back: i_vld=1 and i_rdy=1 for 8 cycles with distinct addresses -> 8 transfers in 8 consecutive cycles, o_rdy stays 1.
- Flush/reset: FULL and stalled, assert i_flush for 1 cycle -> o_vld=0 next cycle, no accept in the flush cycle. Repeat with sreset -> o_vld=0, o_payload=0.

Source files
------------

// File: rtl/regfile_rdctl.sv
// regfile_rdctl: read-side controller for the PQR5 register file.
//
// Sits between decode and execute. A request (two source addresses plus a
// payload) is accepted over a valid/ready handshake. In the accept cycle it
// drives the register file's shared read enable and both read addresses.
// One cycle later it returns both operands together with the payload.
//
// The register file has no write-to-read bypass. Its read registers hold
// their data while the read enable is low. This block therefore snoops the
// write port and overrides any operand whose register is written:
//   - in the accept cycle, because the register file still reads the old value;
//   - while the result is held in a stall, because the held read data is stale.
//
// Ports:
//   clk, sreset              clock; synchronous active-high reset
//   i_flush                  kills the held operation, blocks accepts
//   i_vld / o_rdy            upstream handshake
//   i_rs0_addr, i_rs1_addr   source register addresses
//   i_payload                pass-through payload
//   o_rf_rden, o_rf_rsX_addr register-file read drive
//   i_rf_rsX_data            register-file registered read data
//   i_wb_wren/addr/data      snooped register-file write port
//   o_vld / i_rdy            downstream handshake
//   o_rsX_data, o_rsX_addr   operands and their (held) addresses
//   o_payload                held payload
module regfile_rdctl #(
  parameter int XLEN   = 32,
  parameter int PLD_W  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic             i_flush,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [4:0]       i_rs0_addr,
  input  logic [4:0]       i_rs1_addr,
  input  logic [PLD_W-1:0] i_payload,
  output logic             o_rf_rden,
  output logic [4:0]       o_rf_rs0_addr,
  output logic [4:0]       o_rf_rs1_addr,
  input  logic [XLEN-1:0]  i_rf_rs0_data,
  input  logic [XLEN-1:0]  i_rf_rs1_data,
  input  logic             i_wb_wren,
  input  logic [4:0]       i_wb_rdt_addr,
  input  logic [XLEN-1:0]  i_wb_rdt_data,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [XLEN-1:0]  o_rs0_data,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [4:0]       o_rs0_addr,
  output logic [4:0]       o_rs1_addr,
  output logic [PLD_W-1:0] o_payload
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                      state_q;
  state_t                      state_d;
  logic                        acc;
  logic [1:0][4:0]             req_addr;
  logic [1:0][4:0]             hold_addr_q;
  logic [PLD_W-1:0]            payload_q;
  logic [1:0]                  ovr_q;
  logic [1:0][XLEN-1:0]        ovr_data_q;
  logic [1:0]                  acc_hit;
  logic [1:0]                  hold_hit;

  // Ready is combinational so a new request can enter in the same cycle
  // that the held one leaves.
  assign o_vld = (state_q == FULL);
  assign o_rdy = ~i_flush & (~o_vld | i_rdy);
  assign acc   = i_vld & o_rdy;

  // The read enable is only raised on accept. The register file then keeps
  // the operands in its read registers through a downstream stall.
  assign o_rf_rden     = acc;
  assign o_rf_rs0_addr = i_rs0_addr;
  assign o_rf_rs1_addr = i_rs1_addr;

  assign req_addr = {i_rs1_addr, i_rs0_addr};

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (acc) state_d = FULL;
      end
      FULL: begin
        if (i_flush)    state_d = EMPTY;
        else if (acc)   state_d = FULL;
        else if (i_rdy) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Snoop-hit detection. x0 is never overridden.
  // A hold hit only matters while stalled. On a transfer the held
  // operands leave at this edge anyway.
  always_comb begin
    acc_hit  = '0;
    hold_hit = '0;
    for (int x = 0; x < 2; x++) begin
      acc_hit[x]  = FWD_EN && i_wb_wren && (i_wb_rdt_addr == req_addr[x])
                    && (req_addr[x] != 5'd0);
      hold_hit[x] = FWD_EN && o_vld && !i_rdy && i_wb_wren
                    && (i_wb_rdt_addr == hold_addr_q[x])
                    && (hold_addr_q[x] != 5'd0);
    end
  end

  // Held copies and override registers.
  // Flush beats everything. An accept re-evaluates the flags for the new
  // request only. A later stall write replaces earlier override data.
  always_ff @(posedge clk) begin
    if (sreset) begin
      hold_addr_q <= '0;
      payload_q   <= '0;
      ovr_q       <= '0;
      ovr_data_q  <= '0;
    end else begin
      if (acc) begin
        hold_addr_q <= req_addr;
        payload_q   <= i_payload;
      end
      for (int x = 0; x < 2; x++) begin
        if (i_flush) begin
          ovr_q[x] <= 1'b0;
        end else if (acc) begin
          ovr_q[x] <= acc_hit[x];
          if (acc_hit[x]) ovr_data_q[x] <= i_wb_rdt_data;
        end else if (hold_hit[x]) begin
          ovr_q[x]      <= 1'b1;
          ovr_data_q[x] <= i_wb_rdt_data;
        end else if (o_vld && i_rdy) begin
          ovr_q[x] <= 1'b0;
        end
      end
    end
  end

  assign o_rs0_data = ovr_q[0] ? ovr_data_q[0] : i_rf_rs0_data;
  assign o_rs1_data = ovr_q[1] ? ovr_data_q[1] : i_rf_rs1_data;
  assign o_rs0_addr = hold_addr_q[0];
  assign o_rs1_addr = hold_addr_q[1];
  assign o_payload  = payload_q;

endmodule
